// File: rtl/pwm_pkg.sv
// Shared types and width helpers for the PWM link receive path.
package pwm_pkg;

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_HIGH,
        DEC_LOW,
        DEC_STUCK
    } pwm_dec_state_t;

    // Measurement counters need two bits beyond the duty code so that
    // a full period and the timeout window both fit without wrapping.
    function automatic int meas_width(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pwm_decoder.sv
// PWM receiver: measures high time and period in step units, reconstructs
// the generator duty code and reports lines stuck low or high.
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int N       = 8,
    parameter int TIMEOUT = 2 ** (N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic         valid,
    output logic [N+1:0] high_time,
    output logic [N+1:0] period,
    output logic [N-1:0] duty,
    output logic         stuck,
    output logic         stuck_level
);

    localparam int CW = meas_width(N);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DUTY_MAX = CW'((1 << N) - 1);

    logic s;

    sync_2ff #(.RST_VAL(1'b0)) u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (pwm_in),
        .q     (s)
    );

    pwm_dec_state_t state_q, state_d;
    logic           p_q, p_d;
    logic [CW-1:0]  hcnt_q, hcnt_d, pcnt_q, pcnt_d, ecnt_q, ecnt_d;
    logic           valid_q, valid_d;
    logic [CW-1:0]  ht_q, ht_d, per_q, per_d;
    logic [N-1:0]   duty_q, duty_d;
    logic           stuck_q, stuck_d, lvl_q, lvl_d;

    logic           rise, fall, tmo;
    logic           start_per, to_stuck, pub_norm;
    logic [CW-1:0]  hm1;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        hcnt_d    = hcnt_q;
        pcnt_d    = pcnt_q;
        ecnt_d    = ecnt_q;
        valid_d   = 1'b0;
        ht_d      = ht_q;
        per_d     = per_q;
        duty_d    = duty_q;
        stuck_d   = stuck_q;
        lvl_d     = lvl_q;
        start_per = 1'b0;
        to_stuck  = 1'b0;
        pub_norm  = 1'b0;
        rise      = s & ~p_q;
        fall      = ~s & p_q;
        tmo       = (ecnt_q == TMO_LAST);
        hm1       = hcnt_q - CW'(1);

        if (!ena) begin
            state_d = DEC_IDLE;
            hcnt_d  = '0;
            pcnt_d  = '0;
            ecnt_d  = '0;
            p_d     = 1'b1;
        end else if (step) begin
            p_d = s;
            case (state_q)
                DEC_IDLE: begin
                    if (rise)     start_per = 1'b1;
                    else if (tmo) to_stuck  = 1'b1;
                    else          ecnt_d    = ecnt_q + CW'(1);
                end
                DEC_HIGH, DEC_LOW: begin
                    // Edges take priority over a timeout landing on the same sample.
                    if (state_q == DEC_LOW && rise) begin
                        pub_norm  = 1'b1;
                        start_per = 1'b1;
                    end else if (state_q == DEC_HIGH && fall) begin
                        state_d = DEC_LOW;
                        pcnt_d  = pcnt_q + CW'(1);
                        ecnt_d  = '0;
                    end else if (tmo) begin
                        to_stuck = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + CW'(1);
                        hcnt_d = hcnt_q + CW'(s);
                        ecnt_d = ecnt_q + CW'(1);
                    end
                end
                DEC_STUCK: begin
                    if (rise) begin
                        start_per = 1'b1;
                    end else if (fall) begin
                        state_d = DEC_IDLE;
                        hcnt_d  = '0;
                        pcnt_d  = '0;
                        ecnt_d  = '0;
                    end
                end
                default: state_d = DEC_IDLE;
            endcase
        end

        if (start_per) begin
            state_d = DEC_HIGH;
            hcnt_d  = CW'(1);
            pcnt_d  = CW'(1);
            ecnt_d  = '0;
        end
        // Published counts are the ones accumulated before the closing rise.
        if (pub_norm) begin
            valid_d = 1'b1;
            stuck_d = 1'b0;
            ht_d    = hcnt_q;
            per_d   = pcnt_q;
            duty_d  = (hm1 > DUTY_MAX) ? {N{1'b1}} : hm1[N-1:0];
        end
        if (to_stuck) begin
            state_d = DEC_STUCK;
            valid_d = 1'b1;
            stuck_d = 1'b1;
            lvl_d   = s;
            ht_d    = '0;
            per_d   = '0;
            duty_d  = {N{s}};
        end
    end

    // p resets high so a line already high at startup is not seen as a rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DEC_IDLE;
            p_q     <= 1'b1;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            ecnt_q  <= '0;
            valid_q <= 1'b0;
            ht_q    <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            stuck_q <= 1'b0;
            lvl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            ecnt_q  <= ecnt_d;
            valid_q <= valid_d;
            ht_q    <= ht_d;
            per_q   <= per_d;
            duty_q  <= duty_d;
            stuck_q <= stuck_d;
            lvl_q   <= lvl_d;
        end
    end

    assign valid       = valid_q;
    assign high_time   = ht_q;
    assign period      = per_q;
    assign duty        = duty_q;
    assign stuck       = stuck_q;
    assign stuck_level = lvl_q;

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
Receive end of the PWM link: samples a PWM waveform and measures its high time and period in units of `step` strobes.
It reconstructs the duty code a same-N generator would have been driven with, and flags stuck-low (duty 0) and stuck-high (duty 2^N-1) lines.
It sits beside the PWM generator for loopback self-test and decodes externally supplied PWM inputs.

Parameters:
N, 8, duty code width; CW = N+2 is a local constant (measurement width).
TIMEOUT, 2**(N+1), steps without any edge before the line is declared stuck; must satisfy 2^N < TIMEOUT < 2^CW.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
ena  in  1  decoder enable; low holds the decoder idle.
step  in  1  sample/count strobe, same rate as the generator's step.
pwm_in  in  1  PWM line, asynchronous to clk.
valid  out  1  one-cycle pulse: new result published.
high_time  out  CW  steps sampled high in the last full period.
period  out  CW  steps from rising edge to next rising edge.
duty  out  N  reconstructed duty code.
stuck  out  1  the last published result was a timeout.
stuck_level  out  1  line level at timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0; state is IDLE; counters are 0.
  - Both synchronizer flops are 0; the previous-sample register p is 1, so a line already high never produces a false edge.
- pwm_in passes through a 2-flop synchronizer on every clk, giving s.
- Sampling happens only on cycles with ena=1 and step=1.
  - On those cycles: rise = s & ~p, fall = ~s & p, then p <= s.
  - No state or counter changes on other cycles.
- Counters, all CW bits: hcnt (high samples), pcnt (period samples), ecnt (samples since last edge). No counter can wrap because TIMEOUT < 2^CW.
- States (typedef in package): IDLE, HIGH, LOW, STUCK.
  - IDLE: rise -> HIGH with hcnt=1, pcnt=1, ecnt=0. Otherwise ecnt++.
  - HIGH/LOW: pcnt++, hcnt += s, ecnt++ each sample.
    - fall in HIGH -> LOW, ecnt=0.
    - rise in LOW -> publish, then hcnt=1, pcnt=1, ecnt=0 -> HIGH. Publish uses the counts from before this sample.
  - Timeout: in IDLE/HIGH/LOW, when ecnt reaches TIMEOUT-1 and no edge occurs on this sample -> STUCK. This publishes a stuck result (stuck=1, stuck_level=s, high_time=0, period=0).
  - STUCK: counters frozen. rise -> HIGH (counts=1). fall -> IDLE. No further publishes until a normal period completes.
  - Edge and timeout on the same sample: the edge wins.
- Publish (registered, valid high exactly one clk after the sampling cycle):
  - Normal result: stuck=0; high_time/period are the captured counts; duty = min(high_time-1, 2^N-1).
  - Stuck result: duty = 0 if stuck_level=0, else 2^N-1.
  - Outputs hold between publishes.
- ena=0 (synchronous): state -> IDLE, counters cleared, p <= 1, valid=0; published outputs retained.
- Generator compatibility (same N, same step): duty D in 1..2^N-2 yields high_time=D+1, period=2^N, duty=D.

Decomposition:
- pwm_pkg: pwm_dec_state_t enum; function clog/width helper; CW derivation.
- Sub-module sync_2ff (1-bit, async active-low reset, reset value parameter) for the pwm_in synchronizer.
- Remainder in one FSM + counter module.

Test Plan:
- N=8, step every clk; drive generator pattern D=100 (high 101 steps, low 155) -> after the second rising edge, valid pulses with high_time=101, period=256, duty=100, stuck=0; repeats every 256 steps.
- pwm_in held 0 from reset, ena=1 -> at sample 512, valid with stuck=1, stuck_level=0, duty=0; no further valid.
- pwm_in high before reset release and held -> no rise detected; timeout gives stuck_level=1, duty=255. A later fall then rise, followed by a full period, gives a normal result.
- step asserted 1 of every 4 clks, D=1 -> high_time=2, period=256, duty=1; counters unchanged on non-step cycles.
- Mid-period: drop ena for 10 clks, then raise it -> no valid during or at the first rise after re-enable; the first result arrives one full period later. Repeat with rst=0 asserted asynchronously mid-period -> outputs 0 immediately.
- Glitch: pwm_in pulse shorter than one step interval -> not sampled, no edge; period of 2^N+3 steps with high 5 -> high_time=5, period=259, duty=4.
